// File: rtl/spu_mpy_pkg.sv
// Shared types for the SPU even-side integer multiply pipe.
// The stage record is sized for the widest configuration; a pipe
// instance uses only the low LANES*LANE_W data bits and ADDR_W address bits.
package spu_mpy_pkg;

  localparam int MPY_ADDR_W_MAX = 16;
  localparam int MPY_DATA_W_MAX = 1024;

  typedef enum logic [3:0] {
    MPY_NOP = 4'd0,
    MPY     = 4'd1,
    MPYU    = 4'd2,
    MPYH    = 4'd3,
    MPYHH   = 4'd4,
    MPYS    = 4'd5,
    MPYA    = 4'd6,
    MPYI    = 4'd7,
    MPYUI   = 4'd8
  } mpy_op_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [MPY_ADDR_W_MAX-1:0] rt_addr;
    logic [MPY_DATA_W_MAX-1:0] data;
  } mpy_stage_t;

  // An entry counts as in flight only if it will write the register file.
  function automatic logic stage_writes(input mpy_stage_t s);
    return s.valid && s.reg_write;
  endfunction

endpackage

// File: rtl/spu_mpy_pipe_if.sv
// Issue, writeback and hazard-query bundle of the SPU integer multiply pipe.
// master = issue unit side, slave = multiply pipe side.
interface spu_mpy_pipe_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 7,
  parameter int NSRC   = 5
);

  logic                    in_valid;
  logic [3:0]              op_sel;
  logic [ADDR_W-1:0]       rt_addr;
  logic                    reg_write;
  logic [LANES*LANE_W-1:0] ra;
  logic [LANES*LANE_W-1:0] rb;
  logic [LANES*LANE_W-1:0] rc;
  logic [9:0]              imm;
  logic                    flush;
  logic [NSRC*ADDR_W-1:0]  src_addr;
  logic [NSRC-1:0]         src_valid;

  logic [LANES*LANE_W-1:0] rt_wb;
  logic [ADDR_W-1:0]       rt_addr_wb;
  logic                    reg_write_wb;
  logic [NSRC-1:0]         stall_raw;
  logic [3:0]              inflight_cnt;

  modport master (
    output in_valid, op_sel, rt_addr, reg_write, ra, rb, rc, imm, flush,
           src_addr, src_valid,
    input  rt_wb, rt_addr_wb, reg_write_wb, stall_raw, inflight_cnt
  );

  modport slave (
    input  in_valid, op_sel, rt_addr, reg_write, ra, rb, rc, imm, flush,
           src_addr, src_valid,
    output rt_wb, rt_addr_wb, reg_write_wb, stall_raw, inflight_cnt
  );

endinterface

// File: rtl/spu_mpy_lane.sv
// Combinational single-lane integer multiplier for the SPU multiply pipe.
// All results are truncated to LANE_W bits; the half-width signed products
// are exact in LANE_W bits, so MPYS can shift the full product.
module spu_mpy_lane
  import spu_mpy_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  mpy_op_t           op,
  input  logic [LANE_W-1:0] ra,
  input  logic [LANE_W-1:0] rb,
  input  logic [LANE_W-1:0] rc,
  input  logic [9:0]        imm,
  output logic [LANE_W-1:0] res
);

  localparam int HALF = LANE_W / 2;

  logic signed [LANE_W-1:0] ra_lo_s;
  logic signed [LANE_W-1:0] rb_lo_s;
  logic signed [LANE_W-1:0] ra_hi_s;
  logic signed [LANE_W-1:0] rb_hi_s;
  logic signed [LANE_W-1:0] imm_s;
  logic        [LANE_W-1:0] ra_lo_u;
  logic        [LANE_W-1:0] rb_lo_u;
  logic        [HALF-1:0]   imm_h;
  logic        [LANE_W-1:0] imm_u;
  logic signed [LANE_W-1:0] p_ll;
  logic signed [LANE_W-1:0] p_hl;
  logic signed [LANE_W-1:0] p_hh;

  assign ra_lo_s = {{HALF{ra[HALF-1]}}, ra[HALF-1:0]};
  assign rb_lo_s = {{HALF{rb[HALF-1]}}, rb[HALF-1:0]};
  assign ra_hi_s = {{HALF{ra[LANE_W-1]}}, ra[LANE_W-1:HALF]};
  assign rb_hi_s = {{HALF{rb[LANE_W-1]}}, rb[LANE_W-1:HALF]};
  assign ra_lo_u = {{HALF{1'b0}}, ra[HALF-1:0]};
  assign rb_lo_u = {{HALF{1'b0}}, rb[HALF-1:0]};
  assign imm_s   = LANE_W'($signed(imm));
  assign imm_h   = HALF'($signed(imm));
  assign imm_u   = {{HALF{1'b0}}, imm_h};

  assign p_ll = ra_lo_s * rb_lo_s;
  assign p_hl = ra_hi_s * rb_lo_s;
  assign p_hh = ra_hi_s * rb_hi_s;

  // Select the lane result for the decoded operation; unknown ops give zero.
  always_comb begin
    res = '0;
    case (op)
      MPY:     res = p_ll;
      MPYU:    res = ra_lo_u * rb_lo_u;
      MPYH:    res = p_hl << HALF;
      MPYHH:   res = p_hh;
      MPYS:    res = p_ll >>> HALF;
      MPYA:    res = p_ll + rc;
      MPYI:    res = ra_lo_s * imm_s;
      MPYUI:   res = ra_lo_u * imm_u;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/spu_mpy_pipe.sv
// SPU even-side parametrised integer multiply pipe.
// Shift pipeline of LAT stages with branch-flush kill of the youngest
// entries, a registered in-flight counter and optional RAW-hazard compare.
// Optional feature macro: SPU_MPY_HAZARD_EN (undefined: stall_raw tied to 0).
module spu_mpy_pipe
  import spu_mpy_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int LANE_W      = 32,
  parameter int LAT         = 7,
  parameter int FLUSH_DEPTH = 1,
  parameter int ADDR_W      = 7,
  parameter int NSRC        = 5
) (
  input  logic           clk,
  input  logic           reset,
  spu_mpy_pipe_if.slave  bus
);

  localparam int DW = LANES * LANE_W;

  mpy_op_t           op;
  logic              op_known;
  logic [DW-1:0]     lane_res;
  mpy_stage_t        stage_in;
  mpy_stage_t        stage_q [LAT];
  logic [3:0]        cnt_q;
  logic [3:0]        kill_cnt;
  logic              cap_w;
  logic              leave_w;
  logic [DW-1:0]     wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_wen;
  logic [NSRC-1:0]   stall;
  logic              unused_wb_hi;

  // Decode op_sel; encodings outside the enum behave as NOP.
  always_comb begin
    op       = MPY_NOP;
    op_known = 1'b0;
    case (bus.op_sel)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        op       = mpy_op_t'(bus.op_sel);
        op_known = 1'b1;
      end
      default: begin
        op       = MPY_NOP;
        op_known = 1'b0;
      end
    endcase
  end

  // Lane 0 occupies the most significant bits of each operand vector.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int MSB = DW - 1 - l * LANE_W;
    spu_mpy_lane #(.LANE_W(LANE_W)) u_lane (
      .op  (op),
      .ra  (bus.ra[MSB -: LANE_W]),
      .rb  (bus.rb[MSB -: LANE_W]),
      .rc  (bus.rc[MSB -: LANE_W]),
      .imm (bus.imm),
      .res (lane_res[MSB -: LANE_W])
    );
  end

  // Build the entry entering stage 0; a flush or a non-op gives a bubble.
  always_comb begin
    stage_in = '0;
    if (bus.in_valid && op_known && !bus.flush) begin
      stage_in.valid     = 1'b1;
      stage_in.reg_write = bus.reg_write;
      stage_in.rt_addr   = MPY_ADDR_W_MAX'(bus.rt_addr);
      stage_in.data      = MPY_DATA_W_MAX'(lane_res);
    end
  end

  // Advance the pipeline, clearing the youngest entries on a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < LAT; i++) begin
        if (bus.flush && (i <= FLUSH_DEPTH)) stage_q[i] <= '0;
        else                                 stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Count writing entries that a flush this cycle removes from the pipe.
  always_comb begin
    kill_cnt = '0;
    if (bus.flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        if (stage_writes(stage_q[i])) kill_cnt = kill_cnt + 4'd1;
      end
    end
  end

  assign cap_w   = stage_writes(stage_in);
  assign leave_w = stage_writes(stage_q[LAT-1]);

  // Track writing entries in flight; all events of one edge combine.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + {3'b000, cap_w} - {3'b000, leave_w} - kill_cnt;
  end

  // Present the oldest stage as writeback, zero when it holds a bubble.
  always_comb begin
    wb_data = '0;
    wb_addr = '0;
    wb_wen  = 1'b0;
    if (stage_q[LAT-1].valid) begin
      wb_data = stage_q[LAT-1].data[DW-1:0];
      wb_addr = stage_q[LAT-1].rt_addr[ADDR_W-1:0];
      wb_wen  = stage_q[LAT-1].reg_write;
    end
  end

  assign unused_wb_hi = (|(stage_q[LAT-1].data >> DW)) |
                        (|(stage_q[LAT-1].rt_addr >> ADDR_W));

`ifdef SPU_MPY_HAZARD_EN
  // Flag sources whose register is still being produced in stages 0..LAT-2.
  always_comb begin
    stall = '0;
    if (!reset) begin
      for (int j = 0; j < NSRC; j++) begin
        for (int i = 0; i < LAT - 1; i++) begin
          if (bus.src_valid[j] && stage_writes(stage_q[i]) &&
              (stage_q[i].rt_addr ==
               MPY_ADDR_W_MAX'(bus.src_addr[j*ADDR_W +: ADDR_W])))
            stall[j] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_src;
  assign unused_src = ^{bus.src_addr, bus.src_valid};
  assign stall      = '0;
`endif

  assign bus.rt_wb        = wb_data;
  assign bus.rt_addr_wb   = wb_addr;
  assign bus.reg_write_wb = wb_wen;
  assign bus.stall_raw    = stall;
  assign bus.inflight_cnt = cnt_q;

endmodule

// File: tb/tb_spu_mpy_pipe.sv
// Directed self-checking bench for spu_mpy_pipe: a default 4x32/LAT=7
// instance plus a 2x16/LAT=4 instance, with hand-computed expected values.
module tb_spu_mpy_pipe;
  import spu_mpy_pkg::*;

`ifdef SPU_MPY_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  spu_mpy_pipe_if #(.LANES(4), .LANE_W(32), .ADDR_W(7), .NSRC(5)) bus0 ();
  spu_mpy_pipe_if #(.LANES(2), .LANE_W(16), .ADDR_W(7), .NSRC(5)) bus1 ();

  spu_mpy_pipe #(.LANES(4), .LANE_W(32), .LAT(7), .FLUSH_DEPTH(1),
                 .ADDR_W(7), .NSRC(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  spu_mpy_pipe #(.LANES(2), .LANE_W(16), .LAT(4), .FLUSH_DEPTH(1),
                 .ADDR_W(7), .NSRC(5)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic [3:0]   op;
    logic [6:0]   rt;
    logic         wen;
    logic [127:0] ra, rb, rc;
    logic [9:0]   imm;
    logic         exp_v;
    logic [127:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [6:0] rt,
                               input logic wen, input logic [127:0] ra,
                               input logic [127:0] rb, input logic [127:0] rc,
                               input logic [9:0] imm);
    bus0.in_valid  = 1'b1;
    bus0.op_sel    = op;
    bus0.rt_addr   = rt;
    bus0.reg_write = wen;
    bus0.ra        = ra;
    bus0.rb        = rb;
    bus0.rc        = rc;
    bus0.imm       = imm;
  endtask

  task automatic idle0();
    bus0.in_valid  = 1'b0;
    bus0.op_sel    = 4'd0;
    bus0.rt_addr   = '0;
    bus0.reg_write = 1'b0;
    bus0.ra        = '0;
    bus0.rb        = '0;
    bus0.rc        = '0;
    bus0.imm       = '0;
    bus0.flush     = 1'b0;
  endtask

  task automatic idle1();
    bus1.in_valid  = 1'b0;
    bus1.op_sel    = 4'd0;
    bus1.rt_addr   = '0;
    bus1.reg_write = 1'b0;
    bus1.ra        = '0;
    bus1.rb        = '0;
    bus1.rc        = '0;
    bus1.imm       = '0;
    bus1.flush     = 1'b0;
    bus1.src_addr  = '0;
    bus1.src_valid = '0;
  endtask

  task automatic addVec(input logic [3:0] op, input logic [6:0] rt, input logic wen,
                        input logic [127:0] ra, input logic [127:0] rb,
                        input logic [127:0] rc, input logic [9:0] imm,
                        input logic exp_v, input logic [127:0] exp_d);
    vec_t v;
    v.op = op; v.rt = rt; v.wen = wen; v.ra = ra; v.rb = rb; v.rc = rc;
    v.imm = imm; v.exp_v = exp_v; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  logic [127:0] sm_data [3];
  logic [6:0]   sm_addr [3];

  initial begin
    int exp_cnt;
    int k;

    reset = 1'b1;
    idle0();
    idle1();
    bus0.src_addr  = '0;
    bus0.src_valid = '0;
    tick();
    tick();
    checkOutput("rst_rt_wb", bus0.rt_wb, 128'h0);
    checkOutput("rst_addr_wb", bus0.rt_addr_wb, 128'h0);
    checkOutput("rst_wen", bus0.reg_write_wb, 128'h0);
    checkOutput("rst_cnt", bus0.inflight_cnt, 128'h0);
    checkOutput("rst_stall", bus0.stall_raw, 128'h0);
    checkOutput("rst_small_wen", bus1.reg_write_wb, 128'h0);
    reset = 1'b0;

    // Basic MPY latency: visible only after edge 6.
    applyStimulus(4'(MPY), 7'd5, 1'b1, {4{32'h0000FFFE}}, {4{32'h00000003}}, '0, '0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) idle0();
      checkOutput($sformatf("lat_wen_e%0d", c), bus0.reg_write_wb, (c == 6) ? 128'h1 : 128'h0);
      checkOutput($sformatf("lat_data_e%0d", c), bus0.rt_wb,
                  (c == 6) ? {4{32'hFFFFFFFA}} : 128'h0);
      checkOutput($sformatf("lat_addr_e%0d", c), bus0.rt_addr_wb, (c == 6) ? 128'd5 : 128'h0);
      checkOutput($sformatf("lat_cnt_e%0d", c), bus0.inflight_cnt, (c <= 6) ? 128'd1 : 128'd0);
    end

    // Mixed ops issued back to back.
    addVec(4'(MPYU),  7'd10, 1'b1, {4{32'h0000FFFE}}, {4{32'h00000003}}, '0, '0, 1'b1, {4{32'h0002FFFA}});
    addVec(4'(MPYH),  7'd11, 1'b1, {4{32'h00020000}}, {4{32'h00000003}}, '0, '0, 1'b1, {4{32'h00060000}});
    addVec(4'(MPYS),  7'd12, 1'b1, {4{32'h00004000}}, {4{32'h00004000}}, '0, '0, 1'b1, {4{32'h00001000}});
    addVec(4'(MPYA),  7'd13, 1'b1, {4{32'h00000003}}, {4{32'h00000004}}, {4{32'h0000000A}}, '0, 1'b1, {4{32'h00000016}});
    addVec(4'(MPYHH), 7'd14, 1'b1, {4{32'hFFFF0000}}, {4{32'h00050000}}, '0, '0, 1'b1, {4{32'hFFFFFFFB}});
    addVec(4'(MPYI),  7'd15, 1'b1, {4{32'h00000005}}, '0, '0, 10'h3FD, 1'b1, {4{32'hFFFFFFF1}});
    addVec(4'(MPYUI), 7'd16, 1'b1, {4{32'h00000002}}, '0, '0, 10'h3FF, 1'b1, {4{32'h0001FFFE}});
    addVec(4'hF,      7'd17, 1'b1, {4{32'h00000002}}, {4{32'h00000002}}, '0, '0, 1'b0, 128'h0);
    addVec(4'(MPY_NOP), 7'd17, 1'b1, {4{32'h00000002}}, {4{32'h00000002}}, '0, '0, 1'b0, 128'h0);
    addVec(4'(MPY),   7'd18, 1'b0, {4{32'h00000007}}, {4{32'h00000006}}, '0, '0, 1'b1, {4{32'h0000002A}});
    addVec(4'(MPYS),  7'd20, 1'b1, {4{32'hFFFF8000}}, {4{32'h00000002}}, '0, '0, 1'b1, {4{32'hFFFFFFFF}});
    addVec(4'(MPY),   7'd19, 1'b1,
           {32'h00000002, 32'h00000003, 32'h0000FFFF, 32'h00000010},
           {32'h00000005, 32'h00000007, 32'h00000002, 32'h00000010}, '0, '0, 1'b1,
           {32'h0000000A, 32'h00000015, 32'hFFFFFFFE, 32'h00000100});

    for (int c = 0; c < vecs.size() + 6; c++) begin
      if (c < vecs.size())
        applyStimulus(vecs[c].op, vecs[c].rt, vecs[c].wen, vecs[c].ra, vecs[c].rb,
                      vecs[c].rc, vecs[c].imm);
      else
        idle0();
      tick();
      exp_cnt = 0;
      for (int i = 0; i < vecs.size(); i++)
        if (i <= c && i >= c - 6 && vecs[i].exp_v && vecs[i].wen) exp_cnt++;
      checkOutput($sformatf("mix_cnt_e%0d", c), bus0.inflight_cnt, 128'(exp_cnt));
      if (c >= 6) begin
        k = c - 6;
        checkOutput($sformatf("mix_data_%0d", k), bus0.rt_wb, vecs[k].exp_d);
        checkOutput($sformatf("mix_addr_%0d", k), bus0.rt_addr_wb,
                    vecs[k].exp_v ? 128'(vecs[k].rt) : 128'h0);
        checkOutput($sformatf("mix_wen_%0d", k), bus0.reg_write_wb,
                    (vecs[k].exp_v && vecs[k].wen) ? 128'h1 : 128'h0);
      end
    end
    idle0();
    tick();

    // RAW hazard on r9 through source slot 2.
    bus0.src_addr = '0;
    bus0.src_addr[0*7 +: 7] = 7'd9;
    bus0.src_addr[1*7 +: 7] = 7'd8;
    bus0.src_addr[2*7 +: 7] = 7'd9;
    bus0.src_valid = 5'b00110;
    #1;
    checkOutput("haz_empty", bus0.stall_raw, 128'h0);
    applyStimulus(4'(MPY), 7'd9, 1'b1, {4{32'h00000002}}, {4{32'h00000002}}, '0, '0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) idle0();
      checkOutput($sformatf("haz_e%0d", c), bus0.stall_raw,
                  (HAZ && c <= 5) ? 128'b00100 : 128'h0);
    end
    bus0.src_valid = '0;

    // Flush at edge 2 kills B (r2) and incoming C (r3); A (r1) survives.
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      applyStimulus(4'(MPY), 7'd1, 1'b1, {4{32'h2}}, {4{32'h3}}, '0, '0);
      else if (c == 1) applyStimulus(4'(MPY), 7'd2, 1'b1, {4{32'h4}}, {4{32'h5}}, '0, '0);
      else if (c == 2) begin
        applyStimulus(4'(MPY), 7'd3, 1'b1, {4{32'h6}}, {4{32'h7}}, '0, '0);
        bus0.flush = 1'b1;
      end else idle0();
      tick();
      checkOutput($sformatf("fl_cnt_e%0d", c), bus0.inflight_cnt,
                  (c == 1) ? 128'd2 : ((c <= 6) ? 128'd1 : 128'd0));
      checkOutput($sformatf("fl_wen_e%0d", c), bus0.reg_write_wb, (c == 6) ? 128'h1 : 128'h0);
      checkOutput($sformatf("fl_addr_e%0d", c), bus0.rt_addr_wb, (c == 6) ? 128'd1 : 128'h0);
      checkOutput($sformatf("fl_data_e%0d", c), bus0.rt_wb, (c == 6) ? {4{32'h6}} : 128'h0);
    end

    // Reset with three ops in flight.
    bus0.src_addr = '0;
    bus0.src_addr[0*7 +: 7] = 7'd5;
    bus0.src_valid = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'(MPY), 7'(4 + c), 1'b1, {4{32'h3}}, {4{32'h3}}, '0, '0);
      tick();
    end
    idle0();
    checkOutput("rmid_cnt_pre", bus0.inflight_cnt, 128'd3);
    checkOutput("rmid_stall_pre", bus0.stall_raw, HAZ ? 128'b00001 : 128'h0);
    reset = 1'b1;
    tick();
    checkOutput("rmid_cnt_rst", bus0.inflight_cnt, 128'd0);
    checkOutput("rmid_stall_rst", bus0.stall_raw, 128'h0);
    checkOutput("rmid_wen_rst", bus0.reg_write_wb, 128'h0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("rmid_wen_%0d", c), bus0.reg_write_wb, 128'h0);
      checkOutput($sformatf("rmid_cnt_%0d", c), bus0.inflight_cnt, 128'd0);
      checkOutput($sformatf("rmid_stall_%0d", c), bus0.stall_raw, 128'h0);
    end
    bus0.src_valid = '0;

    // Small configuration: 2 lanes x 16 bits, LAT=4 (HALF=8).
    sm_data[0] = 128'h0000_0000_FF81_FFFD; sm_addr[0] = 7'd7;
    sm_data[1] = 128'h0000_0000_0FF0_01FE; sm_addr[1] = 7'd8;
    sm_data[2] = 128'h0000_0000_0F00_FE00; sm_addr[2] = 7'd9;
    for (int c = 0; c < 7; c++) begin
      idle1();
      bus1.in_valid  = (c < 3);
      bus1.reg_write = (c < 3);
      bus1.rt_addr   = (c < 3) ? sm_addr[c] : 7'd0;
      if (c == 0) begin
        bus1.op_sel = 4'(MPYI);  bus1.ra = {16'h007F, 16'h0003}; bus1.imm = 10'h3FF;
      end else if (c == 1) begin
        bus1.op_sel = 4'(MPYUI); bus1.ra = {16'h0010, 16'h0002}; bus1.imm = 10'h3FF;
      end else if (c == 2) begin
        bus1.op_sel = 4'(MPYH);  bus1.ra = {16'h0300, 16'hFF00}; bus1.rb = {16'h0005, 16'h0002};
      end
      tick();
      if (c == 2) checkOutput("sm_cnt_e2", bus1.inflight_cnt, 128'd3);
      if (c == 4) checkOutput("sm_cnt_e4", bus1.inflight_cnt, 128'd2);
      if (c >= 3 && c <= 5) begin
        checkOutput($sformatf("sm_data_%0d", c - 3), 128'(bus1.rt_wb), sm_data[c-3]);
        checkOutput($sformatf("sm_addr_%0d", c - 3), bus1.rt_addr_wb, 128'(sm_addr[c-3]));
        checkOutput($sformatf("sm_wen_%0d", c - 3), bus1.reg_write_wb, 128'h1);
      end else begin
        checkOutput($sformatf("sm_idle_e%0d", c), bus1.reg_write_wb, 128'h0);
      end
    end
    idle1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
